// File: rtl/trng_sampler.sv
// Ring-oscillator entropy sampler: synchronizes the raw bit, debiases it with a
// von Neumann extractor, packs bytes onto a valid/ready port and runs a repetition-count test.
module trng_sampler #(
   parameter int DIV       = 4,
   parameter int REP_LIMIT = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       rnd_in,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       fault
);

   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int RW = $clog2(REP_LIMIT + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [RW-1:0] REP_MAX  = RW'(REP_LIMIT);
   localparam logic [RW-1:0] REP_ONE  = RW'(1);

   logic          s1_q, s2_q;
   logic [DW-1:0] div_q, div_d;
   logic          half_q, half_d;
   logic          a_q, a_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [7:0]    sh_q, sh_d;
   logic [7:0]    byte_q, byte_d;
   logic          valid_q, valid_d;
   logic [RW-1:0] rep_q, rep_d;
   logic          prev_q, prev_d;
   logic          prev_vld_q, prev_vld_d;
   logic          fault_q, fault_d;

   logic          strobe_s, emit_s, bit_s;
   logic          full_s, free_s, load_s;
   logic [7:0]    packed_s;

   // Sample strobe divider and von Neumann pair extractor
   always_comb begin
      strobe_s = en && (div_q == DIV_LAST);
      div_d    = div_q;
      half_d   = half_q;
      a_d      = a_q;
      emit_s   = 1'b0;
      bit_s    = a_q;
      if (!en) begin
         div_d = '0;
      end else if (strobe_s) begin
         div_d = '0;
      end else begin
         div_d = div_q + DW'(1);
      end
      // Dropping en discards a half-collected pair so later pairs stay aligned
      if (!en) begin
         half_d = 1'b0;
      end else if (strobe_s) begin
         if (!half_q) begin
            a_d    = s2_q;
            half_d = 1'b1;
         end else begin
            half_d = 1'b0;
            emit_s = (a_q != s2_q);
         end
      end else begin
         half_d = half_q;
      end
   end

   // Repetition-count health test on every raw sample
   always_comb begin
      rep_d      = rep_q;
      prev_d     = prev_q;
      prev_vld_d = prev_vld_q;
      if (strobe_s) begin
         prev_d     = s2_q;
         prev_vld_d = 1'b1;
         if (!prev_vld_q || (prev_q != s2_q)) begin
            rep_d = REP_ONE;
         end else if (rep_q == REP_MAX) begin
            rep_d = rep_q;
         end else begin
            rep_d = rep_q + REP_ONE;
         end
      end else begin
         rep_d = rep_q;
      end
      fault_d = fault_q || (rep_d == REP_MAX);
   end

   // Bit packer and output holding register
   always_comb begin
      sh_d     = sh_q;
      cnt_d    = cnt_q;
      byte_d   = byte_q;
      valid_d  = valid_q;
      full_s   = (cnt_q == 4'd8) || (emit_s && (cnt_q == 4'd7));
      packed_s = (cnt_q == 4'd8) ? sh_q : {sh_q[6:0], bit_s};
      free_s   = !valid_q || byte_ready;
      // A trip on this very edge already blocks the load
      load_s   = free_s && full_s && !fault_d;
      if (emit_s && (cnt_q != 4'd8)) begin
         sh_d  = {sh_q[6:0], bit_s};
         cnt_d = cnt_q + 4'd1;
      end else begin
         sh_d  = sh_q;
      end
      if (load_s) begin
         cnt_d   = 4'd0;
         byte_d  = packed_s;
         valid_d = 1'b1;
      end else if (valid_q && byte_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State registers, cleared asynchronously by rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         div_q      <= '0;
         half_q     <= 1'b0;
         a_q        <= 1'b0;
         cnt_q      <= 4'd0;
         sh_q       <= 8'd0;
         byte_q     <= 8'd0;
         valid_q    <= 1'b0;
         rep_q      <= '0;
         prev_q     <= 1'b0;
         prev_vld_q <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         s1_q       <= rnd_in;
         s2_q       <= s1_q;
         div_q      <= div_d;
         half_q     <= half_d;
         a_q        <= a_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         byte_q     <= byte_d;
         valid_q    <= valid_d;
         rep_q      <= rep_d;
         prev_q     <= prev_d;
         prev_vld_q <= prev_vld_d;
         fault_q    <= fault_d;
      end
   end

   assign byte_out   = byte_q;
   assign byte_valid = valid_q;
   assign fault      = fault_q;

endmodule

// File: tb/tb_trng_sampler.sv
// Bench for trng_sampler: two instances (DIV=1/REP_LIMIT=32 and DIV=2/REP_LIMIT=4)
// checked every cycle against a sample-level model plus literal byte expectations.
module tb_trng_sampler;

   logic       clk = 1'b0;
   logic       rst_v [2];
   logic       en_v  [2];
   logic       rnd_v [2];
   logic       rdy_v [2];
   logic [7:0] bo    [2];
   logic       bv    [2];
   logic       flt   [2];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   trng_sampler #(.DIV(1), .REP_LIMIT(32)) dut0 (
      .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .rnd_in(rnd_v[0]),
      .byte_out(bo[0]), .byte_valid(bv[0]), .byte_ready(rdy_v[0]), .fault(flt[0])
   );

   trng_sampler #(.DIV(2), .REP_LIMIT(4)) dut1 (
      .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .rnd_in(rnd_v[1]),
      .byte_out(bo[1]), .byte_valid(bv[1]), .byte_ready(rdy_v[1]), .fault(flt[1])
   );

   // Model: enabled-cycle count decides strobes, raw samples arrive two edges late,
   // pairs are judged, debiased bits fill byte positions MSB first.
   int         m_div [2] = '{1, 2};
   int         m_lim [2] = '{32, 4};
   int         m_en_cycles [2];
   int         m_pend [2];
   int         m_nbits [2];
   int         m_run [2];
   bit         m_late1 [2];
   bit         m_late2 [2];
   bit         m_prev [2];
   bit         m_valid [2];
   bit         m_fault [2];
   logic [7:0] m_acc [2];
   logic [7:0] m_byte [2];
   logic [7:0] got0 [$];
   logic [7:0] got1 [$];

   task automatic model_clear(input int k);
      m_en_cycles[k] = 0; m_pend[k] = -1; m_nbits[k] = 0; m_run[k] = 0;
      m_late1[k] = 1'b0; m_late2[k] = 1'b0; m_prev[k] = 1'b0;
      m_valid[k] = 1'b0; m_fault[k] = 1'b0; m_acc[k] = 8'h00; m_byte[k] = 8'h00;
   endtask

   task automatic model_step(input int k);
      bit smp;
      bit stb;
      bit free;
      if (rst_v[k]) begin
         model_clear(k);
         return;
      end
      smp  = m_late2[k];
      stb  = en_v[k] && ((m_en_cycles[k] % m_div[k]) == m_div[k] - 1);
      free = !m_valid[k] || rdy_v[k];
      m_en_cycles[k] = en_v[k] ? m_en_cycles[k] + 1 : 0;
      if (stb) begin
         if (m_run[k] == 0 || smp != m_prev[k]) m_run[k] = 1;
         else if (m_run[k] < m_lim[k]) m_run[k] = m_run[k] + 1;
         m_prev[k] = smp;
         if (m_run[k] == m_lim[k]) m_fault[k] = 1'b1;
      end
      if (!en_v[k]) m_pend[k] = -1;
      else if (stb) begin
         if (m_pend[k] < 0) m_pend[k] = smp ? 1 : 0;
         else begin
            if ((m_pend[k] == 1) != smp && m_nbits[k] < 8) begin
               m_acc[k][7 - m_nbits[k]] = (m_pend[k] == 1);
               m_nbits[k] = m_nbits[k] + 1;
            end
            m_pend[k] = -1;
         end
      end
      if (free && m_nbits[k] == 8 && !m_fault[k]) begin
         m_byte[k]  = m_acc[k];
         m_valid[k] = 1'b1;
         m_nbits[k] = 0;
         m_acc[k]   = 8'h00;
      end else if (m_valid[k] && rdy_v[k]) begin
         m_valid[k] = 1'b0;
      end
      m_late2[k] = m_late1[k];
      m_late1[k] = rnd_v[k];
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) model_step(k);
   end

   always @(posedge clk) begin
      if (!rst_v[0] && bv[0] && rdy_v[0]) got0.push_back(bo[0]);
      if (!rst_v[1] && bv[1] && rdy_v[1]) got1.push_back(bo[1]);
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("dut%0d.byte_valid", k), int'(bv[k]), int'(m_valid[k]));
         chk($sformatf("dut%0d.byte_out", k), int'(bo[k]), int'(m_byte[k]));
         chk($sformatf("dut%0d.fault", k), int'(flt[k]), int'(m_fault[k]));
      end
   end

   // Sample i of the sequence is b[n-1-i]; each is held DIV cycles, en rises so the
   // first strobe sees sample 0, and en drops after the last strobe.
   task automatic run_seq(input int k, input logic [31:0] b, input int n);
      int d = m_div[k];
      for (int c = 0; c <= n * d + 1; c++) begin
         if (c < n * d) rnd_v[k] = b[n - 1 - c / d];
         if (c == 2) en_v[k] = 1'b1;
         @(negedge clk);
      end
      en_v[k] = 1'b0;
      @(negedge clk);
   endtask

   task automatic expect_byte(input int k, input string name, input int exp);
      logic [7:0] v;
      int have;
      have = (k == 0) ? got0.size() : got1.size();
      if (have == 0) begin
         chk(name, 256, exp);
      end else begin
         if (k == 0) v = got0.pop_front();
         else v = got1.pop_front();
         chk(name, int'(v), exp);
      end
   endtask

   task automatic expect_none(input int k, input string name);
      chk(name, (k == 0) ? got0.size() : got1.size(), 0);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         rst_v[k] = 1'b1; en_v[k] = 1'b0; rnd_v[k] = 1'b0; rdy_v[k] = 1'b0;
         model_clear(k);
      end
      repeat (3) @(negedge clk);
      chk("reset_valid", int'(bv[0]), 0);
      chk("reset_byte", int'(bo[0]), 0);
      chk("reset_fault", int'(flt[1]), 0);
      rst_v[0] = 1'b0; rst_v[1] = 1'b0;
      rdy_v[0] = 1'b1; rdy_v[1] = 1'b1;
      @(negedge clk);

      // Known patterns
      run_seq(0, 32'h0000AAAA, 16);
      expect_byte(0, "known_ff", 8'hFF);
      run_seq(0, 32'h00009999, 16);
      expect_byte(0, "known_aa", 8'hAA);

      // Equal pairs produce no bits
      run_seq(0, 32'h33333333, 32);
      expect_none(0, "equal_pairs_none");
      chk("equal_pairs_valid", int'(bv[0]), 0);
      run_seq(0, 32'h00006666, 16);
      expect_byte(0, "after_equal_55", 8'h55);
      expect_none(0, "after_equal_single");

      // Backpressure: 0x55 held, 0x33 waits in the packer, further bits lost
      rdy_v[0] = 1'b0;
      run_seq(0, 32'h00006666, 16);
      run_seq(0, 32'h00005A5A, 16);
      run_seq(0, 32'h0000AAAA, 16);
      chk("bp_hold_byte", int'(bo[0]), 8'h55);
      chk("bp_hold_valid", int'(bv[0]), 1);
      rdy_v[0] = 1'b1;
      @(negedge clk);
      rdy_v[0] = 1'b0;
      chk("bp_next_byte", int'(bo[0]), 8'h33);
      chk("bp_next_valid", int'(bv[0]), 1);
      repeat (3) @(negedge clk);
      rdy_v[0] = 1'b1;
      repeat (2) @(negedge clk);
      expect_byte(0, "bp_first", 8'h55);
      expect_byte(0, "bp_second", 8'h33);
      expect_none(0, "bp_extra_lost");
      chk("bp_drained", int'(bv[0]), 0);

      // Enable gating drops the half pair
      run_seq(0, 32'h00000013, 5);
      run_seq(0, 32'h00000999, 12);
      expect_byte(0, "gating_aa", 8'hAA);

      // Asynchronous reset with a byte held and five bits packed
      rdy_v[0] = 1'b0;
      run_seq(0, 32'h0000AAAA, 16);
      run_seq(0, 32'h000002AA, 10);
      chk("pre_rst_valid", int'(bv[0]), 1);
      #2 rst_v[0] = 1'b1;
      #1;
      chk("async_rst_valid", int'(bv[0]), 0);
      chk("async_rst_byte", int'(bo[0]), 0);
      chk("async_rst_fault", int'(flt[0]), 0);
      @(negedge clk);
      rst_v[0] = 1'b0;
      rdy_v[0] = 1'b1;
      run_seq(0, 32'h00000015, 6);
      expect_none(0, "rst_fresh_bits_none");
      chk("rst_fresh_valid", int'(bv[0]), 0);
      run_seq(0, 32'h000002AA, 10);
      expect_byte(0, "rst_fresh_1f", 8'h1F);
      expect_none(0, "rst_old_byte_gone");

      // Health test on the DIV=2, REP_LIMIT=4 instance
      run_seq(1, 32'h0000A55A, 16);
      expect_byte(1, "div2_c3", 8'hC3);
      run_seq(1, 32'h00000007, 3);
      chk("fault_before_limit", int'(flt[1]), 0);
      run_seq(1, 32'h00000001, 1);
      chk("fault_at_limit", int'(flt[1]), 1);
      run_seq(1, 32'h0000AAAA, 16);
      expect_none(1, "fault_blocks_bytes");
      chk("fault_blocks_valid", int'(bv[1]), 0);
      chk("fault_sticky", int'(flt[1]), 1);
      rst_v[1] = 1'b1;
      @(negedge clk);
      rst_v[1] = 1'b0;
      chk("fault_cleared", int'(flt[1]), 0);
      run_seq(1, 32'h00006666, 16);
      expect_byte(1, "resume_55", 8'h55);
      expect_none(1, "resume_single");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/trng_sampler.md
# trng_sampler

Entropy consumer for the ring-oscillator source. It samples the free-running raw bit `rnd` into the clock domain at a programmable rate and removes bias with a von Neumann extractor. It packs the debiased bits into bytes and presents each byte on a valid/ready interface. A repetition-count health test flags a stuck source. The block sits between `ring_osc` and any byte-wide consumer in the top level, such as an output port or a register readout.

## Interface
- `DIV`, default 4: sample strobe period in clocks; integer ≥ 1.
- `REP_LIMIT`, default 32: consecutive identical raw samples that trip `fault`; integer ≥ 2.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high; clears all state.
- `en` input 1: sampling enable.
- `rnd_in` input 1: raw oscillator bit, asynchronous to `clk`.
- `byte_out` output 8: packed random byte.
- `byte_valid` output 1: `byte_out` holds an unconsumed byte.
- `byte_ready` input 1: consumer accepts the byte on this edge when `byte_valid` is 1.
- `fault` output 1: sticky health-test failure.

## Operation
- **Synchronizer**: `rnd_in` passes through two flops, s1 then s2, both reset to 0. Only s2 is used downstream.
- **Divider**: counts 0..DIV-1 while `en`=1. When the count equals DIV-1, `strobe` is 1 and the counter wraps to 0. With DIV=1, `strobe` is 1 on every enabled cycle. When `en`=0, the counter holds at 0.
- **Von Neumann extractor**: has a `half` flag plus a stored first bit `a`.
  - On a strobe with `half`=0: store `a`=s2 and set `half`=1.
  - On a strobe with `half`=1: clear `half`. If `a`≠s2, emit the debiased bit `a`. If `a`=s2, emit nothing.
  - `en`=0 clears `half`, so a pending first bit is discarded.
- **Packer**: 8-bit shift register plus a bit count of 0..8.
  - An emitted bit shifts in MSB-first: `sh <= {sh[6:0], bit}`, count+1.
  - While count=8, emitted bits are discarded.
- **Holding register** (`byte_out`/`byte_valid`): it is free when `byte_valid`=0, or when `byte_valid` and `byte_ready` are both 1 on this edge.
  - When it is free and the packer is full, `byte_out` loads the packed byte and `byte_valid` is set to 1.
  - The 8th bit counts as full on the edge it is accepted: if the holding register is free on that edge, the byte loads directly and the count resets to 0.
  - Otherwise the count stays at 8 and the byte loads on the first edge where the holding register is free.
  - Consuming a byte with no new byte loading clears `byte_valid` to 0.
- **Health test**: runs on raw samples at every strobe, independent of `en` gating beyond the strobe itself.
  - The first sample after reset sets the repetition count to 1.
  - A sample equal to the previous sample increments the count, saturating at REP_LIMIT.
  - A sample different from the previous sample sets the count to 1.
  - When the count reaches REP_LIMIT, `fault` is set to 1. It clears only on `rst`.
  - While `fault`=1, no new byte loads into the holding register. A byte already held still drains normally.
- **Handshake rules**:
  - `byte_out` is stable while `byte_valid`=1 and `byte_ready`=0.
  - `byte_valid` never drops without a transfer, except on `rst`.
  - `byte_ready` is ignored while `byte_valid`=0.

## Timing
- Reset values: `byte_out`=0, `byte_valid`=0, `fault`=0, s1=s2=0, divider=0, `half`=0, count=0, `sh`=0, repetition count=0 with the previous-sample marker invalid.
- `rst` asserted at any point, including with `byte_valid`=1 or mid-pair, clears every output immediately (asynchronously).
- Latency from `rnd_in` to s2 is 2 edges.
- A debiased bit enters `sh` on the edge of the second strobe of its pair.
- `byte_valid` rises on the edge that accepts the 8th bit, when the holding register is free.
- Minimum byte interval is 16·DIV clocks, at zero discards.
- Simultaneous transfer (`byte_valid` & `byte_ready`) and a full packer on the same edge: the new byte replaces the old one and `byte_valid` stays 1.
- Simultaneous fault trip and packer full on the same edge: no load.

## Test plan
- **Known pattern**: DIV=1, `byte_ready`=1. Drive sample pairs (1,0)×8 → one byte 0xFF with `byte_valid` high for 1 cycle. Then drive pairs alternating (1,0),(0,1)×4 → 0xAA.
- **Equal pairs discarded**: drive pairs (0,0),(1,1) for 32 samples → no bit counted, `byte_valid` stays 0. Then drive 8 unequal pairs → exactly one byte.
- **Backpressure**: `byte_ready`=0, generate 0x55 then 0x33, then 8 further unequal pairs.
  - `byte_out` must stay 0x55 throughout.
  - Pulse `byte_ready` for 1 cycle → `byte_out`=0x33 on the next cycle with `byte_valid` still 1.
  - The 8 extra pairs are lost.
- **Fault**: REP_LIMIT=4, DIV=2. Hold `rnd_in`=1 → `fault`=1 after the 4th strobe. Further unequal pairs produce no new bytes. Pulse `rst` → `fault`=0 and bytes resume.
- **Enable gating**: deassert `en` after the first sample of a pair, then re-enable → the pair restarts, so pattern bits stay aligned (verify with an 0xAA stream).
- **Async reset mid-operation**: assert `rst` between clock edges while `byte_valid`=1 and count=5 → `byte_valid`, `byte_out` and `fault` are 0 before the next edge. The next byte requires 8 fresh bits.
